// File: rtl/bram_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo_if
// Purpose  : Handshake/status bundle for bram_fifo.
//            Producer side : in_data, in_valid -> in_ready
//            Consumer side : out_data, out_valid <- out_ready
//            Control/status: flush, count, almost_full, overflow
//            master = user of the FIFO, slave = the FIFO itself.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;
  logic                  overflow;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, count, almost_full, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, count, almost_full, overflow
  );
endinterface
`default_nettype wire

// File: rtl/bram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo
// Purpose  : Show-ahead synchronous FIFO built on a simple dual-port block
//            RAM with registered read. A two-deep pipeline (RAM read register
//            + output register) hides the RAM latency so that back-to-back
//            pops run at one word per cycle.
// Ports    : clk    - sole clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - bram_fifo_if.slave: write handshake (in_*), show-ahead
//                     read handshake (out_*), flush, count, almost_full,
//                     sticky overflow
// Revision : 1.0 - initial release
// ============================================================================
module bram_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 4
) (
  input wire          clk,
  input wire          rst_n,
  bram_fifo_if.slave  bus
);

  localparam int                  CW        = ADDR_WIDTH + 1;
  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = CW'(AFULL_THRESH);

  // Storage: no reset so synthesis can map it onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  logic [ADDR_WIDTH-1:0] wr_ptr_q,      wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,      rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,       count_d;
  logic                  pf_valid_q,    pf_valid_d;
  logic                  out_valid_q,   out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
  logic                  in_ready_q,    in_ready_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q,    overflow_d;

  logic                  push;
  logic                  pop;
  logic                  out_load;
  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   ram_words;

  always_comb begin
    push      = bus.in_valid && in_ready_q;
    pop       = out_valid_q && bus.out_ready;
    // Prefetched word moves to the output stage when that stage frees up.
    out_load  = pf_valid_q && (!out_valid_q || pop);
    // Words still sitting in RAM: count covers both pipeline stages too.
    ram_words = count_q - CW'(out_valid_q) - CW'(pf_valid_q);
    rd_en     = (ram_words != '0) && (!pf_valid_q || out_load) && !bus.flush;
    wr_en     = push && !bus.flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pf_valid_d  = pf_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q | (bus.in_valid & ~in_ready_q);

    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (rd_en)         pf_valid_d = 1'b1;
    else if (out_load) pf_valid_d = 1'b0;

    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rd_q;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    // Flush wins over push/pop; any read in flight is simply forgotten.
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pf_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    in_ready_d    = (count_d < DEPTH_CNT);
    almost_full_d = (count_d >= AFULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.in_data;
    if (rd_en) ram_rd_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pf_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      in_ready_q    <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pf_valid_q    <= pf_valid_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      in_ready_q    <= in_ready_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.count       = count_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_fifo
// Purpose  : Directed self-checking bench for bram_fifo (DEPTH = 256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_fifo;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bram_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  bram_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .AFULL_THRESH(252)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards and outputs sampled 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    tick(); tick();
    total++;
    if (bus.count !== 9'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: count=%0d ov=%b ir=%b af=%b of=%b required 0 0 0 0 0",
               bus.count, bus.out_valid, bus.in_ready, bus.almost_full, bus.overflow);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 16'h0001;
    tick();                                   // edge N
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 9'd1) begin
      bad++; $display("FAIL basic_N: ov=%b count=%0d required 0 1", bus.out_valid, bus.count);
    end
    bus.in_data = 16'h0002;
    tick();                                   // edge N+1
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_N1_valid: got %b required 0", bus.out_valid);
    end
    bus.in_data = 16'h0003;
    tick();                                   // edge N+2
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001 || bus.count !== 9'd3) begin
      bad++; $display("FAIL basic_first: ov=%b data=%h count=%0d required 1 0001 3",
                      bus.out_valid, bus.out_data, bus.count);
    end
    bus.in_valid = 1'b0;
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0002) begin
      bad++; $display("FAIL basic_second: ov=%b data=%h required 1 0002", bus.out_valid, bus.out_data);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0003) begin
      bad++; $display("FAIL basic_third: ov=%b data=%h required 1 0003", bus.out_valid, bus.out_data);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 9'd0) begin
      bad++; $display("FAIL basic_empty: ov=%b count=%0d required 0 0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h1000 + i);
      tick();
      total++;
      if (bus.count !== 9'(i + 1) || bus.almost_full !== ((i + 1) >= 252) ||
          bus.in_ready !== ((i + 1) < 256)) begin
        bad++;
        $display("FAIL fill_%0d: count=%0d af=%b ir=%b required %0d %b %b", i, bus.count,
                 bus.almost_full, bus.in_ready, i + 1, (i + 1) >= 252, (i + 1) < 256);
      end
    end
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++; $display("FAIL fill_no_overflow: got %b required 0", bus.overflow);
    end
    bus.in_data = 16'hDEAD;                   // refused word
    tick();
    total++;
    if (bus.overflow !== 1'b1 || bus.count !== 9'd256 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL overflow_set: of=%b count=%0d ir=%b required 1 256 0",
                      bus.overflow, bus.count, bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1000) begin
      bad++; $display("FAIL full_head: ov=%b data=%h required 1 1000", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_full_pop_push();
    int idx;
    logic [15:0] exp;
    bus.in_valid = 1'b1; bus.in_data = 16'hBEEF; bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.count !== 9'd255 || bus.out_data !== 16'h1001 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL full_pop_only: count=%0d data=%h ir=%b required 255 1001 1",
                      bus.count, bus.out_data, bus.in_ready);
    end
    tick();
    total++;
    if (bus.count !== 9'd255 || bus.out_data !== 16'h1002) begin
      bad++; $display("FAIL full_push_pop: count=%0d data=%h required 255 1002", bus.count, bus.out_data);
    end
    bus.in_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 600 && idx < 255; c++) begin
      if (bus.out_valid === 1'b1) begin
        exp = (idx < 254) ? 16'(16'h1002 + idx) : 16'hBEEF;
        total++;
        if (bus.out_data !== exp) begin
          bad++; $display("FAIL drain_%0d: got %h required %h", idx, bus.out_data, exp);
        end
        idx++;
      end
      tick();
    end
    total++;
    if (idx != 255 || bus.count !== 9'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_done: words=%0d count=%0d ov=%b required 255 0 0",
                      idx, bus.count, bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'(16'h2000 + i);
      tick();
    end
    total++;
    if (bus.count !== 9'd10) begin
      bad++; $display("FAIL flush_prefill: count=%0d required 10", bus.count);
    end
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h3333; bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.out_ready = 1'b0; bus.in_data = 16'h4444;
    total++;
    if (bus.count !== 9'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b1 ||
        bus.almost_full !== 1'b0) begin
      bad++; $display("FAIL flush_clear: count=%0d ov=%b of=%b af=%b required 0 0 1 0",
                      bus.count, bus.out_valid, bus.overflow, bus.almost_full);
    end
    tick();                                   // push 0x4444 on edge N
    bus.in_valid = 1'b0;
    total++;
    if (bus.count !== 9'd1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_push_N: count=%0d ov=%b required 1 0", bus.count, bus.out_valid);
    end
    tick();
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4444) begin
      bad++; $display("FAIL flush_new_word: ov=%b data=%h required 1 4444", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 9'd0) begin
      bad++; $display("FAIL flush_after_drain: ov=%b count=%0d required 0 0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    int max_cnt = 0;
    logic acc_in, acc_out;
    while (rcv < 1000 && cyc < 20000) begin
      bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.in_data   = 16'(16'h6000 + sent);
      bus.out_ready = (cyc < 600) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      acc_in  = bus.in_valid && bus.in_ready;
      acc_out = bus.out_valid && bus.out_ready;
      if (acc_out) begin
        total++;
        if (bus.out_data !== 16'(16'h6000 + rcv)) begin
          bad++; $display("FAIL stream_word_%0d: got %h required %h", rcv, bus.out_data,
                          16'(16'h6000 + rcv));
        end
        rcv++;
      end
      tick();
      if (acc_in) sent++;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++;
    if (rcv != 1000) begin
      bad++; $display("FAIL stream_complete: got %0d words required 1000", rcv);
    end
    total++;
    if (max_cnt > 256) begin
      bad++; $display("FAIL stream_max_count: got %0d required <=256", max_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'(16'h7000 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.count !== 9'd50 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_prefill: count=%0d ov=%b required 50 1", bus.count, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.count !== 9'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset_async: count=%0d ov=%b ir=%b af=%b of=%b required 0 0 0 0 0",
                      bus.count, bus.out_valid, bus.in_ready, bus.almost_full, bus.overflow);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.count !== 9'd0) begin
      bad++; $display("FAIL mid_release: ir=%b count=%0d required 1 0", bus.in_ready, bus.count);
    end
    bus.in_valid = 1'b1; bus.in_data = 16'h5555;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5555 || bus.count !== 9'd1) begin
      bad++; $display("FAIL mid_first_word: ov=%b data=%h count=%0d required 1 5555 1",
                      bus.out_valid, bus.out_data, bus.count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_full();
    test_full_pop_push();
    test_flush();
    test_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
